ram_port_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port ram32 backing memory between the instruction-side and data-side sa_cache instances.
- Sequences each cache's refill and write-back beats onto the RAM bus (WE/BE/addr/din/dout).
- Round-robin between requesters; a lock keeps a line transfer contiguous; a hold limit guarantees fairness.
- Sits between the two caches' RAM ports and ram32; the caches see it exactly as they would see ram32, plus a grant.

---
 rtl/ram_port_arbiter_if.sv | 31 +++
 rtl/ram_port_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_if
// Brief    : One requester's RAM port (cache side) toward the arbiter.
// Revision : 1.0
// ============================================================================
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              req;
    logic              lock;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, lock, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Round-robin arbiter sharing single-port ram32 between I/D caches,
//            with transfer lock and a hold limit for fairness.
// Revision : 1.0
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   m0,
    ram_port_arbiter_if.slave   m1,
    output logic                WE,
    output logic [3:0]          BE,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data_w,
    input  logic [DATA_W-1:0]   ram_data_r
);
    localparam int                HOLD_W     = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ptr;
    logic [HOLD_W-1:0] r_hold;
    logic              r_rvalid0;
    logic              r_rvalid1;

    logic              w_own0;
    logic              w_own1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_beat;
    logic              w_my_req;
    logic              w_other_req;
    logic              w_lock;
    logic              w_we;
    logic [3:0]        w_be;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_hold_inc;
    logic [HOLD_W-1:0] w_hold_next;
    logic              w_release;
    state_t            w_handover;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);
    assign w_gnt0 = w_own0 & m0.req;
    assign w_gnt1 = w_own1 & m1.req;
    assign w_beat = w_gnt0 | w_gnt1;

    // Owner-side view of the request bundle; the other side only matters for fairness.
    always_comb begin
        w_my_req    = m0.req;
        w_other_req = m1.req;
        w_lock      = m0.lock;
        w_we        = m0.we;
        w_be        = m0.be;
        w_addr      = m0.addr;
        w_wdata     = m0.wdata;
        if (w_own1) begin
            w_my_req    = m1.req;
            w_other_req = m0.req;
            w_lock      = m1.lock;
            w_we        = m1.we;
            w_be        = m1.be;
            w_addr      = m1.addr;
            w_wdata     = m1.wdata;
        end
    end

    assign w_hold_inc  = w_beat & w_other_req & (r_hold != c_max_hold);
    assign w_hold_next = w_hold_inc ? r_hold + 1'b1 : r_hold;

    // Hold-limit release deliberately ignores lock so a long burst cannot starve the peer.
    assign w_release = (w_own0 | w_own1) &
                       (~w_my_req | (w_beat & ~w_lock) |
                        (w_other_req & (w_hold_next == c_max_hold)));

    assign w_handover = w_other_req ? (w_own0 ? OWN1 : OWN0) : IDLE;

    assign WE         = w_beat & w_we;
    assign BE         = w_beat ? w_be    : 4'b0000;
    assign ram_addr   = w_beat ? w_addr  : '0;
    assign ram_data_w = w_beat ? w_wdata : '0;

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = r_rvalid0;
    assign m1.rvalid = r_rvalid1;
    assign m0.rdata  = r_rvalid0 ? ram_data_r : '0;
    assign m1.rdata  = r_rvalid1 ? ram_data_r : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b0;
            r_hold    <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt0 & ~m0.we;
            r_rvalid1 <= w_gnt1 & ~m1.we;
            case (r_state)
                IDLE: begin
                    r_hold <= '0;
                    if (m0.req && (!m1.req || !r_ptr)) begin
                        r_state <= OWN0;
                    end else if (m1.req) begin
                        r_state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (w_release) begin
                        r_state <= w_handover;
                        r_ptr   <= w_own0;
                        r_hold  <= '0;
                    end else begin
                        r_hold  <= w_hold_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed scenarios plus random traffic against a shadow-memory model.
// Revision : 1.0
// ============================================================================
module tb_ram_port_arbiter;
    localparam int ADDR_W   = 20;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 8;
    localparam int MEM_N    = 4096;

    typedef struct packed {
        logic              idle;
        logic              we;
        logic              lock;
        logic [3:0]        be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              WE;
    logic [3:0]        BE;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_w;
    logic [DATA_W-1:0] ram_data_r;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    ram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_if),
        .m1         (m1_if),
        .WE         (WE),
        .BE         (BE),
        .ram_addr   (ram_addr),
        .ram_data_w (ram_data_w),
        .ram_data_r (ram_data_r)
    );

    always #5 clk = ~clk;

    // RAM contents (environment) and the expected contents (model).
    logic [DATA_W-1:0] mem    [MEM_N];
    logic [DATA_W-1:0] shadow [MEM_N];

    txn_t q0[$];
    txn_t q1[$];
    int   log_q[$];
    int   exp_log[$];

    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_rv0, exp_rv1;
    logic [DATA_W-1:0] exp_d0, exp_d1, last_rd0;
    int   hold0, hold1, wait0, wait1;
    logic s_gnt0, s_gnt1, s_we;
    logic [3:0] s_be;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic lock, input logic [3:0] be,
                                input int addr, input logic [DATA_W-1:0] d);
        txn_t t;
        t       = '0;
        t.we    = we;
        t.lock  = lock;
        t.be    = be;
        t.addr  = ADDR_W'(addr);
        t.wdata = d;
        return t;
    endfunction

    task automatic drive(input txn_t h0, input logic r0, input txn_t h1, input logic r1);
        m0_if.req = r0; m0_if.lock = h0.lock; m0_if.we = h0.we;
        m0_if.be = h0.be; m0_if.addr = h0.addr; m0_if.wdata = h0.wdata;
        m1_if.req = r1; m1_if.lock = h1.lock; m1_if.we = h1.we;
        m1_if.be = h1.be; m1_if.addr = h1.addr; m1_if.wdata = h1.wdata;
    endtask

    // One bus cycle: drive heads, check at negedge, let the RAM act on the edge, retire beats.
    task automatic step();
        txn_t h0, h1, h;
        logic v0, v1, r0, r1, a0, a1;
        h0 = '0; h1 = '0;
        v0 = (q0.size() > 0);
        v1 = (q1.size() > 0);
        if (v0) h0 = q0[0];
        if (v1) h1 = q1[0];
        r0 = v0 && !h0.idle;
        r1 = v1 && !h1.idle;
        drive(h0, r0, h1, r1);
        @(negedge clk);
        s_gnt0 = m0_if.gnt; s_gnt1 = m1_if.gnt;
        s_we = WE; s_be = BE; s_addr = ram_addr; s_wdata = ram_data_w;
        chk("rvalid0", 64'(m0_if.rvalid), 64'(exp_rv0));
        chk("rvalid1", 64'(m1_if.rvalid), 64'(exp_rv1));
        chk("rdata0", 64'(m0_if.rdata), exp_rv0 ? 64'(exp_d0) : 64'd0);
        chk("rdata1", 64'(m1_if.rdata), exp_rv1 ? 64'(exp_d1) : 64'd0);
        if (m0_if.rvalid === 1'b1) last_rd0 = m0_if.rdata;
        chk("gnt_exclusive", 64'(s_gnt0 & s_gnt1), 64'd0);
        chk("gnt0_needs_req", 64'(s_gnt0 & !r0), 64'd0);
        chk("gnt1_needs_req", 64'(s_gnt1 & !r1), 64'd0);
        a0 = (s_gnt0 === 1'b1) && r0;
        a1 = (s_gnt1 === 1'b1) && r1;
        if (a0 || a1) begin
            h = a1 ? h1 : h0;
            chk("bus_we", 64'(s_we), 64'(h.we));
            chk("bus_be", 64'(s_be), 64'(h.be));
            chk("bus_addr", 64'(s_addr), 64'(h.addr));
            if (h.we) chk("bus_wdata", 64'(s_wdata), 64'(h.wdata));
        end else begin
            chk("bus_we_idle", 64'(s_we), 64'd0);
            chk("bus_be_idle", 64'(s_be), 64'd0);
        end
        exp_rv0 = a0 && !h0.we;
        exp_rv1 = a1 && !h1.we;
        exp_d0  = shadow[h0.addr[11:0]];
        exp_d1  = shadow[h1.addr[11:0]];
        if ((a0 || a1) && h.we)
            for (int b = 0; b < 4; b++)
                if (h.be[b]) shadow[h.addr[11:0]][8*b +: 8] = h.wdata[8*b +: 8];
        log_q.push_back(a0 ? 0 : (a1 ? 1 : 2));
        // Fairness: beats taken while the peer waits, and cycles spent waiting.
        if (a0 && r1) hold0++; else if (!r1 || a1) hold0 = 0;
        if (a1 && r0) hold1++; else if (!r0 || a0) hold1 = 0;
        if (r0 && !a0) wait0++; else wait0 = 0;
        if (r1 && !a1) wait1++; else wait1 = 0;
        chk("hold_limit0", 64'(hold0 <= MAX_HOLD), 64'd1);
        chk("hold_limit1", 64'(hold1 <= MAX_HOLD), 64'd1);
        chk("wait_bound0", 64'(wait0 <= MAX_HOLD + 1), 64'd1);
        chk("wait_bound1", 64'(wait1 <= MAX_HOLD + 1), 64'd1);
        @(posedge clk);
        ram_data_r = mem[s_addr[11:0]];
        if (s_we)
            for (int b = 0; b < 4; b++)
                if (s_be[b]) mem[s_addr[11:0]][8*b +: 8] = s_wdata[8*b +: 8];
        #1;
        if (a0 || (v0 && h0.idle)) void'(q0.pop_front());
        if (a1 || (v1 && h1.idle)) void'(q1.pop_front());
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); log_q.delete();
        exp_rv0 = 1'b0; exp_rv1 = 1'b0;
        hold0 = 0; hold1 = 0; wait0 = 0; wait1 = 0;
    endtask

    task automatic do_reset();
        clear_model();
        drive('0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_rv0 || exp_rv1) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(q0.size() == 0 && q1.size() == 0 && !exp_rv0 && !exp_rv1), 64'd1);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, 64'(log_q.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
            chk(tag, 64'(log_q[i]), 64'(exp_log[i]));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < MEM_N; i++) mem[i] = $urandom;
        mem[12'h010] = 32'hDEAD_BEEF;
        mem[12'h200] = 32'hA5A5_A5A5;
        for (int i = 0; i < MEM_N; i++) shadow[i] = mem[i];
        ram_data_r = '0;
        last_rd0   = '0;
        clear_model();
        drive('0, 1'b0, '0, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_gnt0", 64'(m0_if.gnt), 64'd0);
        chk("rst_gnt1", 64'(m1_if.gnt), 64'd0);
        chk("rst_rvalid0", 64'(m0_if.rvalid), 64'd0);
        chk("rst_rvalid1", 64'(m1_if.rvalid), 64'd0);
        chk("rst_we", 64'(WE), 64'd0);
        chk("rst_be", 64'(BE), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single read: grant one cycle after req, data the cycle after
        q0.push_back(mk(1'b0, 1'b0, 4'hF, 'h10, '0));
        run_until_idle(20);
        exp_log = '{2, 0, 2};
        chk_log("t1_log");
        chk("t1_rdata", 64'(last_rd0), 64'h0000_0000_DEAD_BEEF);

        // Simultaneous single reads: m0 then m1 with no bubble, pointer back to m0
        do_reset();
        q0.push_back(mk(1'b0, 1'b0, 4'hF, 'h20, '0));
        q1.push_back(mk(1'b0, 1'b0, 4'hF, 'h21, '0));
        run_until_idle(20);
        exp_log = '{2, 0, 1, 2};
        chk_log("t2_log");
        log_q.delete();
        q0.push_back(mk(1'b0, 1'b0, 4'hF, 'h22, '0));
        q1.push_back(mk(1'b0, 1'b0, 4'hF, 'h23, '0));
        run_until_idle(20);
        chk_log("t2_ptr_log");

        // Locked 4-beat refill by m1; m0 joins during beat 2 and follows immediately
        do_reset();
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, i < 3, 4'hF, 'h100 + i, '0));
        step();
        step();
        q0.push_back(mk(1'b0, 1'b0, 4'hF, 'h30, '0));
        run_until_idle(30);
        exp_log = '{2, 1, 1, 1, 1, 0, 2};
        chk_log("t3_log");

        // Starvation: m0 locked 20 beats, m1 waiting gets in after MAX_HOLD beats
        do_reset();
        for (int i = 0; i < 20; i++) q0.push_back(mk(1'b0, i < 19, 4'hF, 'h40 + i, '0));
        q1.push_back(mk(1'b0, 1'b0, 4'hF, 'h60, '0));
        run_until_idle(100);
        exp_log.delete();
        exp_log.push_back(2);
        for (int i = 0; i < MAX_HOLD; i++) exp_log.push_back(0);
        exp_log.push_back(1);
        for (int i = 0; i < 20 - MAX_HOLD; i++) exp_log.push_back(0);
        exp_log.push_back(2);
        chk_log("t4_log");

        // Partial write, then read back
        do_reset();
        q0.push_back(mk(1'b1, 1'b0, 4'b0011, 'h200, 32'h1234_5678));
        q0.push_back(mk(1'b0, 1'b0, 4'hF, 'h200, '0));
        run_until_idle(30);
        chk("t5_rdata", 64'(last_rd0), 64'h0000_0000_A5A5_5678);
        chk("t5_mem", 64'(mem[12'h200]), 64'h0000_0000_A5A5_5678);

        // Reset in the middle of a locked burst drops the pending read return
        do_reset();
        for (int i = 0; i < 10; i++) q0.push_back(mk(1'b0, 1'b1, 4'hF, 'h70 + i, '0));
        step();
        step();
        step();
        rst = 1'b0;
        exp_rv0 = 1'b0;
        step();
        chk("t6_gnt0", 64'(s_gnt0), 64'd0);
        chk("t6_gnt1", 64'(s_gnt1), 64'd0);
        rst = 1'b1;
        clear_model();
        q0.push_back(mk(1'b0, 1'b0, 4'hF, 'h80, '0));
        q1.push_back(mk(1'b0, 1'b0, 4'hF, 'h81, '0));
        run_until_idle(20);
        exp_log = '{2, 0, 1, 2};
        chk_log("t6_log");

        // Random mixed traffic with idle gaps, checked against the shadow memory
        do_reset();
        for (int i = 0; i < 200; i++) begin
            txn_t t;
            t = mk(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                   4'($urandom_range(1, 15)), 'h400 + $urandom_range(0, 63), $urandom);
            if ($urandom_range(0, 3) == 0) t.idle = 1'b1;
            q0.push_back(t);
            t = mk(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0,
                   4'($urandom_range(1, 15)), 'h400 + $urandom_range(0, 63), $urandom);
            if ($urandom_range(0, 3) == 0) t.idle = 1'b1;
            q1.push_back(t);
        end
        run_until_idle(5000);
        for (int i = 'h400; i < 'h440; i++)
            chk("rand_mem", 64'(mem[i]), 64'(shadow[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
